// File: rtl/serial_add_pkg.sv
// Shared encodings for the digit-serial add/sub/logic unit.
// Ops and FSM states used by serial_add_ctrl and digit_add2.
package serial_add_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int DIGIT_W = 2;

    function automatic logic is_arith(input op_e o);
        return (o == OP_ADD) || (o == OP_SUB);
    endfunction

endpackage

// File: rtl/digit_add2.sv
// Combinational 2-bit slice: add, subtract (B inverted), AND or XOR.
// Carry-out is forced to 0 for the logic ops.
module digit_add2
    import serial_add_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       ci,
    input  op_e        op,
    output logic [1:0] s,
    output logic       co
);

    logic [1:0] b_eff;
    logic [2:0] sum;

    always_comb begin
        b_eff = (op == OP_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {2'b00, ci};
        s     = sum[1:0];
        co    = 1'b0;
        case (op)
            OP_ADD, OP_SUB: co = sum[2];
            OP_AND:         s  = a & b;
            OP_XOR:         s  = a ^ b;
            default:        co = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Digit-serial ALU controller: one 2-bit digit per cycle, LSB first, done pulse at the end.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / DIGIT_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic             cy_q, cy_d, c_q, c_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [1:0] dig_a, dig_b, dig_s;
    logic       dig_co, last_dig;

`ifdef SERIAL_ADD_OVF_EN
    logic       ovf_q, ovf_d;
    logic [1:0] b_eff;
    logic       msb_ci;
`endif

    assign dig_a    = a_q[DIGIT_W*idx_q +: 2];
    assign dig_b    = b_q[DIGIT_W*idx_q +: 2];
    assign last_dig = (idx_q == IDX_W'(N - 1));

    digit_add2 u_digit (
        .a  (dig_a),
        .b  (dig_b),
        .ci (cy_q),
        .op (op_q),
        .s  (dig_s),
        .co (dig_co)
    );

`ifdef SERIAL_ADD_OVF_EN
    // Carry into the MSB is recovered from the sum bit: s1 = a1 ^ b1' ^ c1.
    assign b_eff  = (op_q == OP_SUB) ? ~dig_b : dig_b;
    assign msb_ci = dig_s[1] ^ dig_a[1] ^ b_eff[1];
`endif

    function automatic logic init_carry(input op_e o, input logic cin);
        case (o)
            OP_ADD:  return cin;
            OP_SUB:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cy_d    = cy_q;
        c_d     = c_q;
        idx_d   = idx_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    op_d    = op_e'(op);
                    a_d     = A;
                    b_d     = B;
                    cy_d    = init_carry(op_e'(op), Cin);
                    idx_d   = '0;
                    s_d     = '0;
                    c_d     = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                s_d[DIGIT_W*idx_q +: 2] = dig_s;
                cy_d  = dig_co;
                idx_d = idx_q + IDX_W'(1);
                if (last_dig) begin
                    state_d = DONE;
                    idx_d   = '0;
                    c_d     = is_arith(op_q) ? dig_co : 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = is_arith(op_q) ? (msb_ci ^ dig_co) : 1'b0;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cy_q    <= 1'b0;
            c_q     <= 1'b0;
            idx_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cy_q    <= cy_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign S    = s_q;
    assign C    = c_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl against an arithmetic reference model.
// Overflow checks are compiled in when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

    localparam int W = 8;
    localparam int N = W / 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] A, B;
    logic         Cin;
    logic         busy, done, C;
    logic [W-1:0] S;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .C     (C)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference result from plain integer arithmetic on the whole operands.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, output logic [W-1:0] s, output logic c);
        int unsigned r;
        case (o)
            2'd0: r = int'(a) + int'(b) + int'(ci);
            2'd1: r = int'(a) + ((1 << W) - int'(b));
            2'd2: r = int'(a & b);
            default: r = int'(a ^ b);
        endcase
        s = W'(r);
        c = (o < 2) ? r[W] : 1'b0;
    endfunction

`ifdef SERIAL_ADD_OVF_EN
    function automatic logic model_ovf(input logic [1:0] o, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic ci);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (o == 2'd0)      r = sa + sb + int'(ci);
        else if (o == 2'd1) r = sa - sb;
        else                return 1'b0;
        return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    endfunction
`endif

    // Issue one operation starting at #1 after a posedge with the DUT idle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input bit disturb);
        logic [W-1:0] es, mask;
        logic         ec;
        model(o, a, b, ci, es, ec);
        op = o; A = a; B = b; Cin = ci; start = 1'b1;
        @(posedge clk); #1;
        chk("e0_busy", 32'(busy), 32'd1);
        chk("e0_S", 32'(S), 32'd0);
        chk("e0_done", 32'(done), 32'd0);
        start = disturb;
        op = 2'($urandom); A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        for (int k = 1; k <= N; k++) begin
            @(posedge clk); #1;
            start = (disturb && k == N);
            mask = W'((1 << (2 * k)) - 1);
            if (k < N) begin
                chk("run_S_partial", 32'(S), 32'(es & mask));
                chk("run_done", 32'(done), 32'd0);
                chk("run_busy", 32'(busy), 32'd1);
            end else begin
                chk("res_S", 32'(S), 32'(es));
                chk("res_C", 32'(C), 32'(ec));
                chk("res_done", 32'(done), 32'd1);
                chk("res_busy", 32'(busy), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
                chk("res_ovf", 32'(ovf), 32'(model_ovf(o, a, b, ci)));
`endif
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_S_held", 32'(S), 32'(es));
        chk("idle_C_held", 32'(C), 32'(ec));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'd0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_C", 32'(C), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'd0, 8'h5A, 8'h3C, 1'b0, 1'b0);
        run_op(2'd0, 8'hFF, 8'h01, 1'b1, 1'b0);
        run_op(2'd1, 8'h10, 8'h20, 1'b0, 1'b0);
        run_op(2'd1, 8'h20, 8'h10, 1'b0, 1'b0);
        run_op(2'd2, 8'hF0, 8'h3C, 1'b0, 1'b0);
        run_op(2'd3, 8'hF0, 8'h3C, 1'b0, 1'b0);
        run_op(2'd0, 8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(2'd1, 8'h80, 8'h01, 1'b0, 1'b0);
        run_op(2'd0, 8'h01, 8'h01, 1'b0, 1'b0);
        // Start pulses during RUN and DONE must be ignored; the next op follows immediately.
        run_op(2'd0, 8'h12, 8'h34, 1'b1, 1'b1);
        run_op(2'd1, 8'h00, 8'h01, 1'b0, 1'b0);

        // Reset in the middle of an ADD aborts it without a done pulse.
        op = 2'd0; A = 8'h5A; B = 8'h3C; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_S", 32'(S), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_C", 32'(C), 32'd0);
        for (int k = 0; k < N + 2; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        run_op(2'd0, 8'h5A, 8'h3C, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                   bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
